// File: rtl/simple_dma_if.sv
// Shared request/grant/rvalid bus between a host (master) and a device (slave).
interface simple_dma_if #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32
);
  logic                    req;
  logic                    gnt;
  logic                    we;
  logic [DataWidth/8-1:0]  be;
  logic [AddressWidth-1:0] addr;
  logic [DataWidth-1:0]    wdata;
  logic                    rvalid;
  logic [DataWidth-1:0]    rdata;
  logic                    err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/simple_dma.sv
// Single-channel word-copy DMA: config window (device) plus bus host port.
//
// state   | meaning
// IDLE    | no transfer in progress; START accepted here
// RD_REQ  | read request for cur_src on the bus, waiting for grant
// RD_WAIT | read granted, waiting for read response
// WR_REQ  | write request of the buffered word to cur_dst, waiting for grant
// WR_WAIT | write granted, waiting for write response
module simple_dma #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned LenWidth     = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  simple_dma_if.slave  cfg,
  simple_dma_if.master host,
  output logic         irq_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  localparam logic [9:0] OffSrc    = 10'h000;
  localparam logic [9:0] OffDst    = 10'h004;
  localparam logic [9:0] OffLen    = 10'h008;
  localparam logic [9:0] OffCtrl   = 10'h00C;
  localparam logic [9:0] OffStatus = 10'h010;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [AddressWidth-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [LenWidth-1:0]     len_q, len_d, remain_q, remain_d;
  logic                    irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
  logic [DataWidth-1:0]    buf_q, buf_d;

  logic                    host_req_q, host_req_d, host_we_q, host_we_d;
  logic [DataWidth/8-1:0]  host_be_q, host_be_d;
  logic [AddressWidth-1:0] host_addr_q, host_addr_d;
  logic [DataWidth-1:0]    host_wdata_q, host_wdata_d;

  logic                    cfg_rvalid_q, cfg_rvalid_d, cfg_err_q, cfg_err_d;
  logic [DataWidth-1:0]    cfg_rdata_q, cfg_rdata_d;

  logic [9:0] offset;
  logic       busy, mapped, start, clear;
  logic       unused_addr;

  assign offset      = cfg.addr[9:0];
  assign unused_addr = ^cfg.addr[AddressWidth-1:10];
  assign busy        = (state_q != IDLE);
  assign mapped      = offset inside {OffSrc, OffDst, OffLen, OffCtrl, OffStatus};

  // Register-file writes, config responses, transfer FSM and next host request fields.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remain_d    = remain_q;
    buf_d       = buf_q;
    start       = 1'b0;
    clear       = 1'b0;
    cfg_rvalid_d = cfg.req;
    cfg_err_d    = cfg.req & ~mapped;
    cfg_rdata_d  = '0;

    if (cfg.req && cfg.we) begin
      case (offset)
        OffSrc: if (!busy) begin
          for (int b = 0; b < AddressWidth/8; b++)
            if (cfg.be[b]) src_d[8*b +: 8] = cfg.wdata[8*b +: 8];
          src_d[1:0] = 2'b00;
        end
        OffDst: if (!busy) begin
          for (int b = 0; b < AddressWidth/8; b++)
            if (cfg.be[b]) dst_d[8*b +: 8] = cfg.wdata[8*b +: 8];
          dst_d[1:0] = 2'b00;
        end
        OffLen: if (!busy) begin
          for (int b = 0; b < LenWidth/8; b++)
            if (cfg.be[b]) len_d[8*b +: 8] = cfg.wdata[8*b +: 8];
        end
        OffCtrl: if (cfg.be[0]) begin
          start    = cfg.wdata[0];
          irq_en_d = cfg.wdata[1];
          clear    = cfg.wdata[2];
        end
        default: ;
      endcase
    end

    if (cfg.req && !cfg.we) begin
      case (offset)
        OffSrc:    cfg_rdata_d = DataWidth'(src_q);
        OffDst:    cfg_rdata_d = DataWidth'(dst_q);
        OffLen:    cfg_rdata_d = DataWidth'(len_q);
        OffCtrl:   cfg_rdata_d = DataWidth'({irq_en_q, 1'b0});
        OffStatus: cfg_rdata_d = DataWidth'({err_q, done_q, busy});
        default:   cfg_rdata_d = '0;
      endcase
    end

    // Clear is applied before start so a combined write restarts from a clean status.
    if (clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state_q)
      IDLE: if (start) begin
        done_d    = 1'b0;
        err_d     = 1'b0;
        cur_src_d = src_q;
        cur_dst_d = dst_q;
        remain_d  = len_q;
        if (len_q == '0) done_d = 1'b1;
        else             state_d = RD_REQ;
      end
      RD_REQ: if (host.gnt) state_d = RD_WAIT;
      RD_WAIT: if (host.rvalid) begin
        if (host.err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          buf_d   = host.rdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: if (host.gnt) state_d = WR_WAIT;
      WR_WAIT: if (host.rvalid) begin
        if (host.err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cur_src_d = cur_src_q + AddressWidth'(4);
          cur_dst_d = cur_dst_q + AddressWidth'(4);
          remain_d  = remain_q - LenWidth'(1);
          if (remain_q == LenWidth'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    host_req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    host_we_d    = (state_d == WR_REQ);
    host_be_d    = {(DataWidth/8){host_req_d}};
    host_addr_d  = '0;
    host_wdata_d = '0;
    if (state_d == RD_REQ) begin
      host_addr_d = cur_src_d;
    end else if (state_d == WR_REQ) begin
      host_addr_d  = cur_dst_d;
      host_wdata_d = buf_d;
    end
  end

  // State, register file and registered bus outputs; synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      remain_q     <= '0;
      buf_q        <= '0;
      host_req_q   <= 1'b0;
      host_we_q    <= 1'b0;
      host_be_q    <= '0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cur_src_q    <= cur_src_d;
      cur_dst_q    <= cur_dst_d;
      remain_q     <= remain_d;
      buf_q        <= buf_d;
      host_req_q   <= host_req_d;
      host_we_q    <= host_we_d;
      host_be_q    <= host_be_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_err_q    <= cfg_err_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  // The config window is always ready, so requests are granted immediately.
  assign cfg.gnt    = cfg.req;
  assign cfg.rvalid = cfg_rvalid_q;
  assign cfg.rdata  = cfg_rdata_q;
  assign cfg.err    = cfg_err_q;

  assign host.req   = host_req_q;
  assign host.we    = host_we_q;
  assign host.be    = host_be_q;
  assign host.addr  = host_addr_q;
  assign host.wdata = host_wdata_q;

  assign irq_o = irq_en_q & (done_q | err_q);

endmodule
